// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and types.
//   - DEF_* : default 1280x800 timing (pixels / lines per region)
//   - vga_ctrl_t : control bundle carried alongside the pixel pipeline
//   - vga_total() : total period from active, front porch, sync and back porch
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 32'd1280;
    localparam int unsigned DEF_H_FP     = 32'd64;
    localparam int unsigned DEF_H_SYNC   = 32'd136;
    localparam int unsigned DEF_H_BP     = 32'd200;
    localparam int unsigned DEF_V_ACTIVE = 32'd800;
    localparam int unsigned DEF_V_FP     = 32'd1;
    localparam int unsigned DEF_V_SYNC   = 32'd3;
    localparam int unsigned DEF_V_BP     = 32'd24;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } vga_ctrl_t;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel request / display bundle of the VGA timing generator.
//   master : timing generator (drives coordinates, pixels, syncs; reads r/g/b)
//   slave  : pixel source + display side (drives r/g/b)
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 32'd4,
    parameter int unsigned COORD_W = 32'd11
);
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic [COORD_W-1:0] curr_x;
    logic [COORD_W-1:0] curr_y;
    logic               req_valid;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  r, g, b,
        output curr_x, curr_y, req_valid, pix_r, pix_g, pix_b,
        output hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        output r, g, b,
        input  curr_x, curr_y, req_valid, pix_r, pix_g, pix_b,
        input  hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline with synchronous reset to RST_VAL.
//   clk, rst : clock, synchronous active-high reset
//   din/dout : WIDTH-bit data; DEPTH=0 makes dout a combinational copy of din
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 32'd1,
    parameter int unsigned      DEPTH   = 32'd1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 32'd0) begin : g_pass
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Next-state of every stage: shift by one towards the output.
        always_comb begin
            stage_d[0] = din;
            for (int unsigned i = 32'd1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // Pipeline registers, all cleared to the inactive value on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a latency-matched pixel path.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : master side of vga_timing_gen_if
//              curr_x/curr_y/req_valid request a pixel (combinational from counters),
//              r/g/b return it PIX_LAT cycles later, pix_*/de/hsync/vsync/
//              line_start/frame_start all appear PIX_LAT+1 cycles after the request.
// Each axis is ordered sync, back porch, active, front porch.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned COLOR_W  = 32'd4,
    parameter int unsigned COORD_W  = 32'd11,
    parameter int unsigned PIX_LAT  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);

    localparam int unsigned     H_TOTAL   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned     V_TOTAL   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint unsigned COORD_MAX = (64'd1 << COORD_W) - 64'd1;

    localparam logic [COORD_W-1:0] ONE         = COORD_W'(32'd1);
    localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 32'd1);
    localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 32'd1);
    localparam logic [COORD_W-1:0] H_SYNC_END  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_END  = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_ACT_FIRST = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] V_ACT_FIRST = COORD_W'(V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] H_ACT_LAST  = COORD_W'(H_SYNC + H_BP + H_ACTIVE - 32'd1);
    localparam logic [COORD_W-1:0] V_ACT_LAST  = COORD_W'(V_SYNC + V_BP + V_ACTIVE - 32'd1);

    localparam vga_ctrl_t CTRL_IDLE = vga_ctrl_t'({~H_POL, ~V_POL, 1'b0, 1'b0});

    // Counter ranges must fit the coordinate width; refuse to elaborate otherwise.
    if (64'(H_TOTAL) - 64'd1 > COORD_MAX) begin : g_h_range_err
        $error("vga_timing_gen: H_TOTAL-1 does not fit in COORD_W bits");
    end
    if (64'(V_TOTAL) - 64'd1 > COORD_MAX) begin : g_v_range_err
        $error("vga_timing_gen: V_TOTAL-1 does not fit in COORD_W bits");
    end
    if (PIX_LAT > 32'd4) begin : g_lat_range_err
        $error("vga_timing_gen: PIX_LAT must be in 0..4");
    end

    logic [COORD_W-1:0] hcnt_q, hcnt_d;
    logic [COORD_W-1:0] vcnt_q, vcnt_d;
    logic               h_active_s, v_active_s, req_valid_s;
    logic [COORD_W-1:0] curr_x_s, curr_y_s;
    vga_ctrl_t          ctrl_raw_s, ctrl_dly_s, ctrl_d, ctrl_q;
    logic               de_src_s, de_d, de_q;
    logic [COLOR_W-1:0] pix_r_d, pix_g_d, pix_b_d;
    logic [COLOR_W-1:0] pix_r_q, pix_g_q, pix_b_q;

    // Raster counters: hcnt every cycle, vcnt on each hcnt wrap.
    always_comb begin
        hcnt_d = hcnt_q + ONE;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = {COORD_W{1'b0}};
            if (vcnt_q == V_LAST) begin
                vcnt_d = {COORD_W{1'b0}};
            end else begin
                vcnt_d = vcnt_q + ONE;
            end
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    // Request stage and raw (undelayed) control signals.
    always_comb begin
        h_active_s  = (hcnt_q >= H_ACT_FIRST) && (hcnt_q <= H_ACT_LAST);
        v_active_s  = (vcnt_q >= V_ACT_FIRST) && (vcnt_q <= V_ACT_LAST);
        req_valid_s = h_active_s && v_active_s;
        if (req_valid_s) begin
            curr_x_s = hcnt_q - H_ACT_FIRST;
            curr_y_s = vcnt_q - V_ACT_FIRST;
        end else begin
            curr_x_s = {COORD_W{1'b0}};
            curr_y_s = {COORD_W{1'b0}};
        end
        ctrl_raw_s.hsync       = (hcnt_q < H_SYNC_END) ? H_POL : ~H_POL;
        ctrl_raw_s.vsync       = (vcnt_q < V_SYNC_END) ? V_POL : ~V_POL;
        ctrl_raw_s.line_start  = (hcnt_q == {COORD_W{1'b0}});
        ctrl_raw_s.frame_start = (hcnt_q == {COORD_W{1'b0}}) && (vcnt_q == {COORD_W{1'b0}});
    end

    // Control bundle and de_src both trail the request by the source latency;
    // the output registers below add the final cycle.
    vga_delay_line #(
        .WIDTH   ($bits(vga_ctrl_t)),
        .DEPTH   (PIX_LAT),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (ctrl_raw_s),
        .dout (ctrl_dly_s)
    );

    vga_delay_line #(
        .WIDTH   (32'd1),
        .DEPTH   (PIX_LAT),
        .RST_VAL (1'b0)
    ) u_de_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (req_valid_s),
        .dout (de_src_s)
    );

    // Output stage next-state: colour is blanked outside the active area.
    always_comb begin
        ctrl_d = ctrl_dly_s;
        de_d   = de_src_s;
        if (de_src_s) begin
            pix_r_d = bus.r;
            pix_g_d = bus.g;
            pix_b_d = bus.b;
        end else begin
            pix_r_d = {COLOR_W{1'b0}};
            pix_g_d = {COLOR_W{1'b0}};
            pix_b_d = {COLOR_W{1'b0}};
        end
    end

    // All state registers; reset returns everything to the idle raster origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= {COORD_W{1'b0}};
            vcnt_q  <= {COORD_W{1'b0}};
            ctrl_q  <= CTRL_IDLE;
            de_q    <= 1'b0;
            pix_r_q <= {COLOR_W{1'b0}};
            pix_g_q <= {COLOR_W{1'b0}};
            pix_b_q <= {COLOR_W{1'b0}};
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            ctrl_q  <= ctrl_d;
            de_q    <= de_d;
            pix_r_q <= pix_r_d;
            pix_g_q <= pix_g_d;
            pix_b_q <= pix_b_d;
        end
    end

    assign bus.curr_x      = curr_x_s;
    assign bus.curr_y      = curr_y_s;
    assign bus.req_valid   = req_valid_s;
    assign bus.pix_r       = pix_r_q;
    assign bus.pix_g       = pix_g_q;
    assign bus.pix_b       = pix_b_q;
    assign bus.de          = de_q;
    assign bus.hsync       = ctrl_q.hsync;
    assign bus.vsync       = ctrl_q.vsync;
    assign bus.line_start  = ctrl_q.line_start;
    assign bus.frame_start = ctrl_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: five small-timing instances (H 8/2/3/2, V 4/1/2/1, H_POL=1,
// PIX_LAT 0..4) fed r=curr_x[3:0] through a source delay of PIX_LAT and g=b=4'hF,
// plus one default 1280x800 instance with PIX_LAT=1.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0]  hs_v, vs_v, de_v, ls_v, fs_v, rv_v;
    logic [3:0]  pr_a [5];
    logic [3:0]  pg_a [5];
    logic [3:0]  pb_a [5];
    logic [10:0] cx_a [5];
    logic [10:0] cy_a [5];

    for (genvar L = 0; L < 5; L++) begin : g_lat
        vga_timing_gen_if #(.COLOR_W(4), .COORD_W(11)) sif ();

        // Pixel source model: returns curr_x[3:0] exactly L cycles after the request.
        if (L == 0) begin : g_src0
            assign sif.r = sif.curr_x[3:0];
        end else begin : g_srcn
            logic [3:0] pipe_q [L];
            always @(posedge clk) begin
                pipe_q[0] <= sif.curr_x[3:0];
                for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign sif.r = pipe_q[L-1];
        end
        assign sif.g = 4'hF;
        assign sif.b = 4'hF;

        vga_timing_gen #(
            .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
            .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
            .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(4), .COORD_W(11), .PIX_LAT(L)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sif)
        );

        assign hs_v[L] = sif.hsync;
        assign vs_v[L] = sif.vsync;
        assign de_v[L] = sif.de;
        assign ls_v[L] = sif.line_start;
        assign fs_v[L] = sif.frame_start;
        assign rv_v[L] = sif.req_valid;
        assign pr_a[L] = sif.pix_r;
        assign pg_a[L] = sif.pix_g;
        assign pb_a[L] = sif.pix_b;
        assign cx_a[L] = sif.curr_x;
        assign cy_a[L] = sif.curr_y;
    end

    vga_timing_gen_if #(.COLOR_W(4), .COORD_W(11)) dif ();
    assign dif.r = 4'hF;
    assign dif.g = 4'hF;
    assign dif.b = 4'hF;

    vga_timing_gen u_dut_def (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Small-timing expectation at t cycles after reset release, for latency L.
    task automatic check_small(input int L, input int t);
        int u, p, h, v, p0, h0, v0;
        bit act, act0;
        string n;
        n  = $sformatf("lat%0d_t%0d", L, t);
        u  = t - (L + 1);
        p0 = t % 120; h0 = p0 % 15; v0 = p0 / 15;
        act0 = (h0 >= 5) && (h0 <= 12) && (v0 >= 3) && (v0 <= 6);
        chk({n, "_req_valid"}, int'(rv_v[L]), int'(act0));
        chk({n, "_curr_x"}, int'(cx_a[L]), act0 ? h0 - 5 : 0);
        chk({n, "_curr_y"}, int'(cy_a[L]), act0 ? v0 - 3 : 0);
        if (u < 0) begin
            chk({n, "_hsync"}, int'(hs_v[L]), 0);
            chk({n, "_vsync"}, int'(vs_v[L]), 0);
            chk({n, "_de"}, int'(de_v[L]), 0);
            chk({n, "_line_start"}, int'(ls_v[L]), 0);
            chk({n, "_frame_start"}, int'(fs_v[L]), 0);
            chk({n, "_pix_r"}, int'(pr_a[L]), 0);
            chk({n, "_pix_gb"}, int'({pg_a[L], pb_a[L]}), 0);
        end else begin
            p = u % 120; h = p % 15; v = p / 15;
            act = (h >= 5) && (h <= 12) && (v >= 3) && (v <= 6);
            chk({n, "_hsync"}, int'(hs_v[L]), (h < 3) ? 1 : 0);
            chk({n, "_vsync"}, int'(vs_v[L]), (v < 2) ? 1 : 0);
            chk({n, "_de"}, int'(de_v[L]), int'(act));
            chk({n, "_line_start"}, int'(ls_v[L]), (h == 0) ? 1 : 0);
            chk({n, "_frame_start"}, int'(fs_v[L]), (p == 0) ? 1 : 0);
            chk({n, "_pix_r"}, int'(pr_a[L]), act ? (h - 5) : 0);
            chk({n, "_pix_gb"}, int'({pg_a[L], pb_a[L]}), act ? 255 : 0);
        end
    endtask

    // Default-timing expectation (first lines only: all in vsync, never active).
    task automatic check_def(input int t);
        int u, h, v;
        string n;
        n = $sformatf("def_t%0d", t);
        u = t - 2;
        chk({n, "_req_valid"}, int'(dif.req_valid), 0);
        chk({n, "_de"}, int'(dif.de), 0);
        chk({n, "_pix_r"}, int'(dif.pix_r), 0);
        if (u < 0) begin
            chk({n, "_hsync"}, int'(dif.hsync), 1);
            chk({n, "_vsync"}, int'(dif.vsync), 0);
            chk({n, "_line_start"}, int'(dif.line_start), 0);
            chk({n, "_frame_start"}, int'(dif.frame_start), 0);
        end else begin
            h = u % 1680; v = u / 1680;
            chk({n, "_hsync"}, int'(dif.hsync), (h < 136) ? 0 : 1);
            chk({n, "_vsync"}, int'(dif.vsync), (v < 3) ? 1 : 0);
            chk({n, "_line_start"}, int'(dif.line_start), (h == 0) ? 1 : 0);
            chk({n, "_frame_start"}, int'(dif.frame_start), (h == 0 && v == 0) ? 1 : 0);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int L = 0; L < 5; L++) begin
            chk($sformatf("%s_lat%0d_ctrl", tag, L),
                int'({hs_v[L], vs_v[L], de_v[L], ls_v[L], fs_v[L], rv_v[L]}), 0);
            chk($sformatf("%s_lat%0d_pix", tag, L), int'({pr_a[L], pg_a[L], pb_a[L]}), 0);
            chk($sformatf("%s_lat%0d_coord", tag, L), int'({cx_a[L], cy_a[L]}), 0);
        end
        chk({tag, "_def_syncs"}, int'({dif.hsync, dif.vsync}), 2);
        chk({tag, "_def_de_pulses"}, int'({dif.de, dif.line_start, dif.frame_start}), 0);
    endtask

    // Holds rst for the given number of clock edges; returns at t=0 after release.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic run_sweep(input int n);
        int hs_low = 0;
        int vs_high = 0;
        for (int t = 0; t < n; t++) begin
            if (t > 0) begin
                @(negedge clk);
                #1;
            end
            for (int L = 0; L < 5; L++) check_small(L, t);
            check_def(t);
            if (t >= 2 && t < 1682 && dif.hsync == 1'b0) hs_low++;
            if (t >= 2 && t < 3362 && dif.vsync == 1'b1) vs_high++;
        end
        if (n >= 3362) begin
            chk("def_hsync_low_per_line", hs_low, 136);
            chk("def_vsync_high_two_lines", vs_high, 3360);
        end
    endtask

    typedef struct {
        int t;
        bit hs, vs, de, ls, fs;
        int pr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Hand-computed PIX_LAT=1 outputs: value at t is the raster point t-2.
        vecs[0]  = '{t:  1, hs:0, vs:0, de:0, ls:0, fs:0, pr:0};
        vecs[1]  = '{t:  2, hs:1, vs:1, de:0, ls:1, fs:1, pr:0};
        vecs[2]  = '{t:  5, hs:0, vs:1, de:0, ls:0, fs:0, pr:0};
        vecs[3]  = '{t: 17, hs:1, vs:1, de:0, ls:1, fs:0, pr:0};
        vecs[4]  = '{t: 32, hs:1, vs:0, de:0, ls:1, fs:0, pr:0};
        vecs[5]  = '{t: 52, hs:0, vs:0, de:1, ls:0, fs:0, pr:0};
        vecs[6]  = '{t: 55, hs:0, vs:0, de:1, ls:0, fs:0, pr:3};
        vecs[7]  = '{t: 59, hs:0, vs:0, de:1, ls:0, fs:0, pr:7};
        vecs[8]  = '{t: 60, hs:0, vs:0, de:0, ls:0, fs:0, pr:0};
        vecs[9]  = '{t:107, hs:1, vs:0, de:0, ls:1, fs:0, pr:0};
        vecs[10] = '{t:122, hs:1, vs:1, de:0, ls:1, fs:1, pr:0};
        vecs[11] = '{t:123, hs:1, vs:1, de:0, ls:0, fs:0, pr:0};

        do_reset(4);
        check_idle("reset");

        begin
            int cur = 0;
            for (int i = 0; i < 12; i++) begin
                while (cur < vecs[i].t) begin
                    @(negedge clk);
                    #1;
                    cur++;
                end
                chk($sformatf("vec%0d_hsync", i), int'(hs_v[1]), int'(vecs[i].hs));
                chk($sformatf("vec%0d_vsync", i), int'(vs_v[1]), int'(vecs[i].vs));
                chk($sformatf("vec%0d_de", i), int'(de_v[1]), int'(vecs[i].de));
                chk($sformatf("vec%0d_line_start", i), int'(ls_v[1]), int'(vecs[i].ls));
                chk($sformatf("vec%0d_frame_start", i), int'(fs_v[1]), int'(vecs[i].fs));
                chk($sformatf("vec%0d_pix_r", i), int'(pr_a[1]), vecs[i].pr);
                chk($sformatf("vec%0d_pix_g", i), int'(pg_a[1]), vecs[i].de ? 15 : 0);
            end
        end

        // Two default-timing lines and many small frames from a clean reset.
        do_reset(2);
        run_sweep(3400);

        // Move into the active area of the small frames, then reset for 3 cycles.
        repeat (30) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_idle($sformatf("midreset%0d", k));
        end
        rst = 1'b0;
        #1;
        run_sweep(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- H_ACTIVE 1280: visible pixels per line.
- H_FP 64: horizontal front porch.
- H_SYNC 136: horizontal sync width.
- H_BP 200: horizontal back porch.
- V_ACTIVE 800: visible lines.
- V_FP 1: vertical front porch.
- V_SYNC 3: vertical sync lines.
- V_BP 24: vertical back porch.
- H_POL 0: hsync asserted level.
- V_POL 1: vsync asserted level.
- COLOR_W 4: bits per colour channel.
- COORD_W 11: coordinate and counter width.
- PIX_LAT 1: source pixel latency in cycles, range 0..4.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: pixel clock.
- rst, in, 1: reset.
- r / g / b, in, COLOR_W each: source colour, valid PIX_LAT cycles after the matching curr_x/curr_y.
- curr_x / curr_y, out, COORD_W each: active-area coordinate being requested.
- req_valid, out, 1: curr_x/curr_y lie inside the active area.
- pix_r / pix_g / pix_b, out, COLOR_W each: colour to the DAC.
- hsync / vsync, out, 1: sync outputs.
- de, out, 1: display enable, aligned with pix_*.
- line_start, out, 1: one-cycle pulse at the start of each line.
- frame_start, out, 1: one-cycle pulse at the start of each frame.

REQ-003 There SHALL be one clock; reset is synchronous and active-high.

Function
REQ-004 H_TOTAL SHALL be H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL SHALL be V_SYNC+V_BP+V_ACTIVE+V_FP; each region is ordered sync, back porch, active, front porch.
REQ-005 hcnt SHALL count 0..H_TOTAL-1 every clk and wrap to 0; vcnt SHALL advance only on an hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-006 Horizontal active SHALL be hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]; vertical active is defined the same way on vcnt.
REQ-007 Request stage (combinational from the counters):
- req_valid = h_active AND v_active.
- curr_x = hcnt-(H_SYNC+H_BP) and curr_y = vcnt-(V_SYNC+V_BP) when req_valid; both are 0 otherwise.
REQ-008 Raw sync SHALL be asserted (H_POL/V_POL) for hcnt < H_SYNC and vcnt < V_SYNC respectively; deasserted otherwise.
REQ-009 Raw line_start SHALL be true when hcnt==0; raw frame_start is true when hcnt==0 AND vcnt==0.
REQ-010 req_valid SHALL be delayed PIX_LAT cycles to form de_src; each pix_* output register loads the matching r/g/b when de_src=1, else 0.
REQ-011 de, hsync, vsync, line_start and frame_start SHALL be delayed PIX_LAT+1 cycles from their raw values, so all outputs align with pix_* in the same cycle.
REQ-012 Total latency from a request at coordinate (x,y) to the matching pixel on pix_* SHALL be exactly PIX_LAT+1 cycles for every PIX_LAT in 0..4.
REQ-013 Arithmetic SHALL be unsigned at COORD_W bits; H_TOTAL-1 and V_TOTAL-1 must be representable, otherwise elaboration fails (static assertion).
REQ-014 Colour values outside de SHALL be forced to 0 regardless of r/g/b.

Reset
REQ-015 While rst=1 at a clk edge: hcnt=0, vcnt=0, and every delay-line stage is cleared to its inactive value.
REQ-016 Output values during reset:
- pix_*=0, de=0, line_start=0, frame_start=0.
- hsync=~H_POL, vsync=~V_POL.
- curr_x=curr_y=0, req_valid=0.
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately; no stale pulses emerge from the delay lines after release.
REQ-018 On the first clk after rst falls, hcnt SHALL be 0, and frame_start goes high exactly PIX_LAT+1 cycles later.

Structure
REQ-019 Package vga_pkg SHALL hold the default timing constants (1280x800 set above) and a function computing the total from active, fp, sync and bp.
REQ-020 One sub-module vga_delay_line SHALL be used: parameters WIDTH, DEPTH and RST_VAL, synchronous reset, DEPTH=0 meaning pass-through. It is instantiated for the control bundle and for de_src.

Verification
REQ-021 Defaults, PIX_LAT=1, run 2 frames:
- hsync is low for 136 cycles per 1680.
- vsync is high for 3 lines per 828.
- de is high for 1280x800 cycles per frame.
REQ-022 Drive r=curr_x[3:0] delayed by PIX_LAT, PIX_LAT=0..4 -> pix_r equals x[3:0] whenever de=1, with req-to-output delay exactly PIX_LAT+1.
REQ-023 Assert rst for 3 cycles at hcnt=900, vcnt=400:
- During reset, outputs hold the REQ-016 values.
- frame_start pulses PIX_LAT+1 cycles after release.
- No line_start occurs before that pulse.
REQ-024 Small timing (H 8/2/3/2, V 4/1/2/1), H_POL=1 -> period is 15x8=120 cycles, and frame_start pulses once per 120 cycles.
REQ-025 Drive r=g=b=4'hF constantly -> pix_* is 0 on every cycle where de=0, including porches and the final active pixel +1.
